min_disp_pipe: RTL and testbench

Pipelined, back-pressurable winner-takes-all disparity selector. It is the successor to the combinational per-lane argmin stage and sits between the cost-aggregation stage and the disparity output stream. For each of `SAMPLES` pixel lanes it reduces `MAX_DISP` matching costs to the argmin index through a registered comparison tree. It also tracks the second-best cost so that ambiguous matches can be rejected with a per-frame uniqueness threshold.

---
 rtl/stereo_pkg.sv | 22 ++
 rtl/min_disp_pipe_if.sv | 29 ++
 rtl/min_tree_lane.sv | 37 +++
 rtl/min_disp_pipe.sv | 65 ++++++
 tb/tb_min_disp_pipe.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/stereo_pkg.sv
// stereo_pkg: shared min-tree node type, merge rule and uniqueness constants.
// Node fields are NODE_W wide so any DATA_WIDTH up to 16 fits zero-extended.
package stereo_pkg;
   localparam int NODE_W = 16;
   localparam int UNIQ_SHIFT = 4;
   localparam int UNIQ_MAX = 16;
   typedef struct packed {
      logic [NODE_W-1:0] cost;
      logic [NODE_W-1:0] idx;
      logic [NODE_W-1:0] second;
   } min_node_t;
   function automatic logic [NODE_W-1:0] min2(input logic [NODE_W-1:0] x, input logic [NODE_W-1:0] y);
      min2 = (y < x) ? y : x;
   endfunction
   // a covers the lower index range, so it wins ties
   function automatic min_node_t merge_node(input min_node_t a, input min_node_t b);
      logic b_wins;
      b_wins = b.cost < a.cost;
      merge_node = b_wins ? b : a;
      merge_node.second = min2(b_wins ? a.cost : b.cost, min2(a.second, b.second));
   endfunction
endpackage

// File: rtl/min_disp_pipe_if.sv
// min_disp_pipe_if: cost input stream, uniqueness config and disparity output stream.
interface min_disp_pipe_if #(
   parameter int MAX_DISP = 64,
   parameter int SAMPLES = 4,
   parameter int DATA_WIDTH = 8,
   parameter int AXIS_TDATA_WIDTH = 32
);
   logic [SAMPLES-1:0][MAX_DISP-1:0][DATA_WIDTH-1:0] s_axis_costs_tdata;
   logic s_axis_costs_tvalid;
   logic s_axis_costs_tready;
   logic s_axis_costs_tlast;
   logic s_axis_costs_tuser;
   logic [4:0] cfg_uniq_num;
   logic [AXIS_TDATA_WIDTH-1:0] m_axis_min_tdata;
   logic m_axis_min_tvalid;
   logic m_axis_min_tready;
   logic m_axis_min_tlast;
   logic m_axis_min_tuser;
   modport master (
      output s_axis_costs_tdata, s_axis_costs_tvalid, s_axis_costs_tlast, s_axis_costs_tuser,
      output cfg_uniq_num, m_axis_min_tready,
      input s_axis_costs_tready, m_axis_min_tdata, m_axis_min_tvalid, m_axis_min_tlast, m_axis_min_tuser
   );
   modport slave (
      input s_axis_costs_tdata, s_axis_costs_tvalid, s_axis_costs_tlast, s_axis_costs_tuser,
      input cfg_uniq_num, m_axis_min_tready,
      output s_axis_costs_tready, m_axis_min_tdata, m_axis_min_tvalid, m_axis_min_tlast, m_axis_min_tuser
   );
endinterface

// File: rtl/min_tree_lane.sv
// min_tree_lane: one lane's registered argmin tree (heap-indexed, root at 1) plus uniqueness stage.
module min_tree_lane
   import stereo_pkg::*;
#(
   parameter int MAX_DISP = 64,
   parameter int DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] INVALID_DISP = '1
) (
   input logic clk,
   input logic rst,
   input logic en_i,
   input logic [MAX_DISP-1:0][DATA_WIDTH-1:0] costs_i,
   input logic [4:0] uniq_i,
   output logic [DATA_WIDTH-1:0] disp_o
);
   localparam int W = DATA_WIDTH + 5;
   min_node_t node_q [1:MAX_DISP-1];
   min_node_t full [1:2*MAX_DISP-1];
   logic [W-1:0] lhs, rhs;
   logic [DATA_WIDTH-1:0] disp_d, disp_q;
   // node n merges 2n and 2n+1; each heap depth is one register stage
   always_comb begin
      for (int n = 1; n < MAX_DISP; n++) full[n] = node_q[n];
      for (int d = 0; d < MAX_DISP; d++)
         full[MAX_DISP+d] = '{cost: NODE_W'(costs_i[d]), idx: NODE_W'(d), second: NODE_W'({DATA_WIDTH{1'b1}})};
   end
   always_ff @(posedge clk)
      if (en_i)
         for (int n = 1; n < MAX_DISP; n++) node_q[n] <= merge_node(full[2*n], full[2*n+1]);
   assign lhs = W'(node_q[1].second) << UNIQ_SHIFT;
   assign rhs = W'(node_q[1].cost) * W'({1'b0, uniq_i} + 6'(UNIQ_MAX));
   assign disp_d = (lhs < rhs) ? INVALID_DISP : DATA_WIDTH'(node_q[1].idx);
   always_ff @(posedge clk)
      if (rst) disp_q <= '0;
      else if (en_i) disp_q <= disp_d;
   assign disp_o = disp_q;
endmodule

// File: rtl/min_disp_pipe.sv
// min_disp_pipe: pipelined back-pressurable WTA disparity selector with uniqueness rejection.
// Owns the shared valid/last/user/uniq pipeline; lanes hold only data.
module min_disp_pipe
   import stereo_pkg::*;
#(
   parameter int MAX_DISP = 64,
   parameter int SAMPLES = 4,
   parameter int DATA_WIDTH = 8,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] INVALID_DISP = '1
) (
   input logic axis_aclk,
   input logic axis_rst,
   min_disp_pipe_if.slave bus
);
   localparam int LOG2 = $clog2(MAX_DISP);
   logic en, acc;
   logic [LOG2:0] vld_q, last_q, user_q;
   logic [4:0] uniq_q, uniq_d;
   logic [4:0] uq_q [LOG2];
   logic [SAMPLES*DATA_WIDTH-1:0] disp;
   assign en = bus.m_axis_min_tready | ~vld_q[LOG2];
   assign acc = en & bus.s_axis_costs_tvalid;
   // a start-of-frame beat already uses its own new threshold
   assign uniq_d = (acc & bus.s_axis_costs_tuser) ?
      ((bus.cfg_uniq_num > 5'(UNIQ_MAX)) ? 5'(UNIQ_MAX) : bus.cfg_uniq_num) : uniq_q;
   always_ff @(posedge axis_aclk)
      if (axis_rst) begin
         vld_q <= '0;
         last_q <= '0;
         user_q <= '0;
         uniq_q <= '0;
      end else begin
         uniq_q <= uniq_d;
         if (en) begin
            vld_q <= {vld_q[LOG2-1:0], bus.s_axis_costs_tvalid};
            last_q <= {last_q[LOG2-1:0], bus.s_axis_costs_tlast};
            user_q <= {user_q[LOG2-1:0], bus.s_axis_costs_tuser};
         end
      end
   always_ff @(posedge axis_aclk)
      if (en) begin
         uq_q[0] <= uniq_d;
         for (int k = 1; k < LOG2; k++) uq_q[k] <= uq_q[k-1];
      end
   for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
      min_tree_lane #(
         .MAX_DISP(MAX_DISP),
         .DATA_WIDTH(DATA_WIDTH),
         .INVALID_DISP(INVALID_DISP)
      ) u_lane (
         .clk(axis_aclk),
         .rst(axis_rst),
         .en_i(en),
         .costs_i(bus.s_axis_costs_tdata[i]),
         .uniq_i(uq_q[LOG2-1]),
         .disp_o(disp[DATA_WIDTH*i +: DATA_WIDTH])
      );
   end
   assign bus.s_axis_costs_tready = en;
   assign bus.m_axis_min_tdata = AXIS_TDATA_WIDTH'(disp);
   assign bus.m_axis_min_tvalid = vld_q[LOG2];
   assign bus.m_axis_min_tlast = last_q[LOG2];
   assign bus.m_axis_min_tuser = user_q[LOG2];
endmodule

// File: tb/tb_min_disp_pipe.sv
// tb_min_disp_pipe: random and directed stimulus against a queue-based argmin/uniqueness model.
module tb_min_disp_pipe;
   localparam int MD = 64;
   localparam int S = 4;
   localparam int DW = 8;
   localparam int AW = 32;
   typedef logic [S-1:0][MD-1:0][DW-1:0] costs_t;
   typedef logic [AW+1:0] out_t;
   logic clk = 0;
   logic rst = 1;
   always #5 clk = ~clk;
   min_disp_pipe_if #(.MAX_DISP(MD), .SAMPLES(S), .DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(AW)) bus ();
   min_disp_pipe #(.MAX_DISP(MD), .SAMPLES(S), .DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(AW)) dut (
      .axis_aclk(clk),
      .axis_rst(rst),
      .bus(bus)
   );
   int checks = 0;
   int failures = 0;
   out_t exp_q [$];
   int m_uniq = 0;
   logic hold = 0;
   out_t held = '0;
   costs_t c;
   int n;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   // argmin with lowest index on ties; second is the smallest other cost
   function automatic logic [AW-1:0] model(input costs_t cc, input int u);
      logic [AW-1:0] r = '0;
      for (int l = 0; l < S; l++) begin
         int best = 0;
         int sec = 1 << 30;
         for (int d = 1; d < MD; d++) if (cc[l][d] < cc[l][best]) best = d;
         for (int d = 0; d < MD; d++) if (d != best && int'(cc[l][d]) < sec) sec = int'(cc[l][d]);
         r[l*DW +: DW] = (sec * 16 < int'(cc[l][best]) * (16 + u)) ? {DW{1'b1}} : DW'(best);
      end
      return r;
   endfunction
   function automatic costs_t rand_costs(input int lo, input int hi);
      costs_t r;
      for (int l = 0; l < S; l++)
         for (int d = 0; d < MD; d++) r[l][d] = DW'($urandom_range(hi, lo));
      return r;
   endfunction
   task automatic cyc(input logic v, input costs_t cc, input logic last, input logic user,
                      input logic [4:0] cfg, input logic rdy);
      out_t cur;
      @(negedge clk);
      bus.s_axis_costs_tvalid = v;
      bus.s_axis_costs_tdata = cc;
      bus.s_axis_costs_tlast = last;
      bus.s_axis_costs_tuser = user;
      bus.cfg_uniq_num = cfg;
      bus.m_axis_min_tready = rdy;
      #1;
      cur = {bus.m_axis_min_tlast, bus.m_axis_min_tuser, bus.m_axis_min_tdata};
      if (hold) check("stall_stable", {bus.m_axis_min_tvalid, cur}, {1'b1, held});
      if (bus.m_axis_min_tvalid && rdy) begin
         check("beat_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("beat", cur, exp_q.pop_front());
      end
      hold = bus.m_axis_min_tvalid && !rdy;
      held = cur;
      if (v && bus.s_axis_costs_tready) begin
         if (user) m_uniq = (cfg > 16) ? 16 : int'(cfg);
         exp_q.push_back({last, user, model(cc, m_uniq)});
      end
   endtask
   task automatic rst_pulse();
      @(negedge clk);
      rst = 1;
      bus.s_axis_costs_tvalid = 0;
      bus.m_axis_min_tready = 0;
      @(negedge clk);
      rst = 0;
      #1;
      check("rst_tvalid", bus.m_axis_min_tvalid, 0);
      check("rst_out", {bus.m_axis_min_tlast, bus.m_axis_min_tuser, bus.m_axis_min_tdata}, 0);
      check("rst_tready", bus.s_axis_costs_tready, 1);
      exp_q.delete();
      m_uniq = 0;
      hold = 0;
   endtask
   task automatic lat_test(input costs_t cc);
      int k = 0;
      cyc(1, cc, 0, 0, 0, 1);
      do begin
         cyc(0, cc, 0, 0, 0, 1);
         k++;
      end while (!bus.m_axis_min_tvalid && k < 20);
      check("latency", k, 7);
   endtask
   task automatic drain();
      int k = 0;
      while (exp_q.size() > 0 && k < 100) begin
         cyc(0, '0, 0, 0, 0, 1);
         k++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask
   initial begin
      bus.s_axis_costs_tvalid = 0;
      bus.s_axis_costs_tdata = '0;
      bus.s_axis_costs_tlast = 0;
      bus.s_axis_costs_tuser = 0;
      bus.cfg_uniq_num = 0;
      bus.m_axis_min_tready = 0;
      rst_pulse();
      c = rand_costs(0, 255);
      for (int d = 0; d < MD; d++) c[0][d] = 200;
      c[0][37] = 5;
      lat_test(c);
      c = rand_costs(0, 3);
      for (int d = 0; d < MD; d++) c[0][d] = 90;
      c[0][3] = 10;
      c[0][50] = 10;
      cyc(1, c, 0, 0, 0, 1);
      c = rand_costs(30, 60);
      for (int d = 0; d < MD; d++) c[0][d] = 100;
      c[0][9] = 40;
      c[0][20] = 45;
      cyc(1, c, 0, 1, 4, 1);
      c[0][20] = 60;
      cyc(1, c, 1, 0, 0, 1);
      drain();
      cyc(1, rand_costs(100, 110), 0, 1, 0, 1);
      for (int i = 0; i < 6; i++) cyc(1, rand_costs(100, 110), 0, 0, 16, 1);
      cyc(1, rand_costs(100, 110), 0, 1, 16, 1);
      for (int i = 0; i < 3; i++) cyc(1, rand_costs(100, 110), i == 2, 0, 0, 1);
      cyc(1, rand_costs(100, 130), 0, 1, 31, 1);
      cyc(1, rand_costs(100, 130), 0, 0, 2, 1);
      drain();
      for (int i = 0; i < 400; i++) begin
         c = ($urandom_range(1, 0) != 0) ? rand_costs(100, 115) : rand_costs(0, 255);
         cyc($urandom_range(3, 0) != 0, c, $urandom_range(7, 0) == 0, $urandom_range(15, 0) == 0,
             5'($urandom_range(31, 0)), $urandom_range(1, 0) != 0);
      end
      drain();
      for (int i = 0; i < 5; i++) cyc(1, rand_costs(0, 255), 0, i == 0, 8, 1);
      rst_pulse();
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, '0, 0, 0, 0, 1);
         n += int'(bus.m_axis_min_tvalid);
      end
      check("post_rst_quiet", n, 0);
      lat_test(rand_costs(0, 255));
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
